ssd_decoder: RTL and testbench
==============================

SSD_DECODER -- requirements
Module: ssd_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digit positions (2..8).
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical samples needed before capture (2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 an_in  input  NUM_DIGITS  digit select, active-low; one zero bit selects one position.
REQ-006 seg_in  input  7  segment pattern, active-low (bit0=a .. bit6=g).
REQ-007 out_ready  input  1  consumer accepts the frame this cycle.
REQ-008 err_clr  input  1  single-cycle clear of the sticky flags.
REQ-009 out_valid  output  1  frame snapshot available.
REQ-010 out_digits  output  4*NUM_DIGITS  BCD snapshot; position i at bits [4i+3:4i].
REQ-011 digit_valid  output  NUM_DIGITS  live per-position flag: last capture decoded legally.
REQ-012 err_pattern  output  1  sticky: an illegal pattern was captured.
REQ-013 err_overrun  output  1  sticky: a frame completed while the previous frame was unaccepted.

Function
REQ-014 Decode table, all other patterns illegal: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9.
REQ-015 Inputs are registered once; stability counter resets to 0 when the registered {an_in,seg_in} differs from the previous sample, else increments, saturating at STABLE_CYCLES-1.
REQ-016 With inputs changed and held from clock edge k, the capture takes effect at edge k+STABLE_CYCLES; exactly one capture per stable window.
REQ-017 Capture only when an_in has exactly one zero bit; all-ones or multiple zeros are ignored (no capture, no error).
REQ-018 Legal capture: position register <= decoded value, digit_valid[i] <= 1, capture mask bit i <= 1.
REQ-019 Illegal capture: position register unchanged, digit_valid[i] <= 0, mask bit i unchanged, err_pattern <= 1.
REQ-020 FSM states COLLECT and PRESENT; reset state COLLECT.
REQ-021 COLLECT -> PRESENT on the edge where the mask becomes all-ones: out_digits <= all position registers (including the value captured that edge), mask <= 0, out_valid <= 1.
REQ-022 PRESENT: out_digits and out_valid held stable until out_valid & out_ready; captures and mask accumulation continue.
REQ-023 PRESENT, on accept: if the mask is all-ones (including a capture on the same edge), reload the snapshot, clear the mask and stay in PRESENT with out_valid=1; else go to COLLECT, out_valid <= 0.
REQ-024 PRESENT, mask becomes all-ones with no accept that edge: err_overrun <= 1; the mask stays full; out_digits is not overwritten.
REQ-025 Repeated captures of one position within a frame overwrite the register; the latest legal value wins.
REQ-026 err_clr clears both sticky flags; a set condition on the same edge wins (flag stays 1).
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 rst_n low asynchronously forces: out_valid=0, out_digits=0, digit_valid=0, err_pattern=0, err_overrun=0, mask=0, position registers=0, stability counter=0, sample registers=all-ones, state=COLLECT.
REQ-029 Reset asserted mid-frame or mid-window discards the partial frame; after release, the first capture requires a full STABLE_CYCLES window.

Verification (NUM_DIGITS=4, STABLE_CYCLES=4)
REQ-030 Drive an_in=1110 with 0x30 for 4 cycles, then 1101/0x19, 1011/0x12, 0111/0x40, 4 cycles each, out_ready=0 -> out_valid=1, out_digits=16'h0543, digit_valid=1111.
REQ-031 Hold an_in=1110 with seg 0x79 for 3 cycles only, then change -> no capture; digit_valid[0] and mask unchanged.
REQ-032 Capture 0x7F at position 2 -> err_pattern=1, digit_valid[2]=0, register 2 keeps its old value; err_clr pulse -> err_pattern=0.
REQ-033 Complete frame A (digits 1,2,3,4), keep out_ready=0, complete frame B (digits 5,6,7,8) -> err_overrun=1, out_digits still A; pulse out_ready -> next cycle out_valid=1 with B.
REQ-034 an_in=1100 held for 10 cycles -> no capture, no error flags.
REQ-035 Assert rst_n=0 after 2 of 4 digits are captured -> all outputs 0 immediately; after release a full 4-digit sequence is required before out_valid.

Source files
------------

// File: rtl/ssd_decoder.sv
// Recovers the digit values shown on a multiplexed, active-low 7-segment display and presents them as complete BCD frames.
// Latency: a capture lands STABLE_CYCLES edges after the inputs settle, and the frame snapshot is registered on the edge that captures the last position.
// Backpressure: out_valid/out_digits hold until out_ready; captures keep accumulating, and a second full frame sets err_overrun.
module ssd_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [6:0]              seg_in,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    err_pattern,
    output logic                    err_overrun
);
    localparam int SW = NUM_DIGITS + 7;

    typedef enum logic [0:0] {COLLECT, PRESENT} state_t;

    state_t                  state_q;
    logic [SW-1:0]           samp_q, prev_q;
    logic [7:0]              cnt_q;
    logic [3:0]              pos_q [NUM_DIGITS];
    logic [3:0]              pos_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [NUM_DIGITS-1:0]   dv_q, dv_d;
    logic [4*NUM_DIGITS-1:0] snap_d, out_digits_q;
    logic                    out_valid_q, err_pat_q, err_ovr_q;

    logic [NUM_DIGITS-1:0]   sel;
    logic [3:0]              dec_val;
    logic                    dec_ok, one_hot, stable_hit, cap, cap_ok, cap_bad, full, ovr_set;

    // The capture fires exactly once per window: when the counter steps into saturation.
    assign stable_hit = (samp_q == prev_q) && (cnt_q == 8'(STABLE_CYCLES - 2));
    assign sel        = ~samp_q[SW-1:7];
    assign one_hot    = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    assign cap        = stable_hit && one_hot;
    assign cap_ok     = cap && dec_ok;
    assign cap_bad    = cap && !dec_ok;

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        case (samp_q[6:0])
            7'h40: dec_val = 4'd0;
            7'h79: dec_val = 4'd1;
            7'h24: dec_val = 4'd2;
            7'h30: dec_val = 4'd3;
            7'h19: dec_val = 4'd4;
            7'h12: dec_val = 4'd5;
            7'h02: dec_val = 4'd6;
            7'h78: dec_val = 4'd7;
            7'h00: dec_val = 4'd8;
            7'h10: dec_val = 4'd9;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        mask_d = mask_q | (cap_ok ? sel : '0);
        dv_d   = dv_q;
        snap_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pos_d[i] = pos_q[i];
            if (cap_ok && sel[i]) pos_d[i] = dec_val;
            if (cap && sel[i])    dv_d[i]  = dec_ok;
            snap_d[4*i +: 4] = pos_d[i];
        end
    end

    assign full    = &mask_d;
    assign ovr_set = (state_q == PRESENT) && !out_ready && full && !(&mask_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '1;
            prev_q <= '1;
            cnt_q  <= '0;
        end else begin
            samp_q <= {an_in, seg_in};
            prev_q <= samp_q;
            if (samp_q != prev_q)
                cnt_q <= '0;
            else if (cnt_q != 8'(STABLE_CYCLES - 1))
                cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            mask_q       <= '0;
            dv_q         <= '0;
            out_digits_q <= '0;
            out_valid_q  <= 1'b0;
            err_pat_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) pos_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) pos_q[i] <= pos_d[i];
            dv_q      <= dv_d;
            err_pat_q <= cap_bad | (err_pat_q & ~err_clr);
            err_ovr_q <= ovr_set | (err_ovr_q & ~err_clr);
            case (state_q)
                COLLECT: begin
                    if (full) begin
                        out_digits_q <= snap_d;
                        mask_q       <= '0;
                        out_valid_q  <= 1'b1;
                        state_q      <= PRESENT;
                    end else begin
                        mask_q <= mask_d;
                    end
                end
                PRESENT: begin
                    if (out_ready && full) begin
                        out_digits_q <= snap_d;
                        mask_q       <= '0;
                    end else if (out_ready) begin
                        mask_q      <= mask_d;
                        out_valid_q <= 1'b0;
                        state_q     <= COLLECT;
                    end else begin
                        // A full mask is held so the pending frame is reloaded on the next accept.
                        mask_q <= mask_d;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_digits  = out_digits_q;
    assign digit_valid = dv_q;
    assign err_pattern = err_pat_q;
    assign err_overrun = err_ovr_q;
endmodule

// File: tb/tb_ssd_decoder.sv
// Directed bench for ssd_decoder at NUM_DIGITS=4, STABLE_CYCLES=4: table of display windows and handshake pulses, plus a mid-frame reset.
module tb_ssd_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an_in = 4'b1111;
    logic [6:0]  seg_in = 7'h7F;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        out_valid;
    logic [15:0] out_digits;
    logic [3:0]  digit_valid;
    logic        err_pattern, err_overrun;

    int tests = 0;
    int fails = 0;

    ssd_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .an_in(an_in), .seg_in(seg_in),
        .out_ready(out_ready), .err_clr(err_clr), .out_valid(out_valid),
        .out_digits(out_digits), .digit_valid(digit_valid),
        .err_pattern(err_pattern), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // kind: 0 = show an/seg for 'hold' cycles, 1 = out_ready pulse, 2 = err_clr pulse
    typedef struct {
        int          kind;
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic        ov;
        logic [15:0] dig;
        logic [3:0]  dv;
        logic        ep;
        logic        eo;
    } vec_t;

    vec_t tv[26];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ov, input logic [15:0] dig,
                             input logic [3:0] dv, input logic ep, input logic eo);
        check({tag, ".out_valid"},   {15'd0, out_valid},   {15'd0, ov});
        check({tag, ".out_digits"},  out_digits,           dig);
        check({tag, ".digit_valid"}, {12'd0, digit_valid}, {12'd0, dv});
        check({tag, ".err_pattern"}, {15'd0, err_pattern}, {15'd0, ep});
        check({tag, ".err_overrun"}, {15'd0, err_overrun}, {15'd0, eo});
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int hold);
        @(negedge clk);
        an_in  = an;
        seg_in = seg;
        repeat (hold) @(posedge clk);
        #1;
        an_in  = 4'b1111;
        seg_in = 7'h7F;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 1) out_ready = 1'b1; else err_clr = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tv[0]  = '{0, 4'b1110, 7'h79, 3,  1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};
        tv[1]  = '{0, 4'b1110, 7'h30, 4,  1'b0, 16'h0000, 4'b0001, 1'b0, 1'b0};
        tv[2]  = '{0, 4'b1101, 7'h19, 4,  1'b0, 16'h0000, 4'b0011, 1'b0, 1'b0};
        tv[3]  = '{0, 4'b1011, 7'h12, 4,  1'b0, 16'h0000, 4'b0111, 1'b0, 1'b0};
        tv[4]  = '{0, 4'b0111, 7'h40, 4,  1'b1, 16'h0543, 4'b1111, 1'b0, 1'b0};
        tv[5]  = '{0, 4'b1110, 7'h79, 3,  1'b1, 16'h0543, 4'b1111, 1'b0, 1'b0};
        tv[6]  = '{1, 4'b1111, 7'h7F, 0,  1'b0, 16'h0543, 4'b1111, 1'b0, 1'b0};
        tv[7]  = '{0, 4'b1100, 7'h40, 10, 1'b0, 16'h0543, 4'b1111, 1'b0, 1'b0};
        tv[8]  = '{0, 4'b1011, 7'h78, 4,  1'b0, 16'h0543, 4'b1111, 1'b0, 1'b0};
        tv[9]  = '{0, 4'b1011, 7'h7F, 4,  1'b0, 16'h0543, 4'b1011, 1'b1, 1'b0};
        tv[10] = '{0, 4'b1110, 7'h00, 4,  1'b0, 16'h0543, 4'b1011, 1'b1, 1'b0};
        tv[11] = '{0, 4'b1101, 7'h02, 4,  1'b0, 16'h0543, 4'b1011, 1'b1, 1'b0};
        tv[12] = '{0, 4'b0111, 7'h24, 4,  1'b1, 16'h2768, 4'b1011, 1'b1, 1'b0};
        tv[13] = '{2, 4'b1111, 7'h7F, 0,  1'b1, 16'h2768, 4'b1011, 1'b0, 1'b0};
        tv[14] = '{1, 4'b1111, 7'h7F, 0,  1'b0, 16'h2768, 4'b1011, 1'b0, 1'b0};
        tv[15] = '{0, 4'b1110, 7'h79, 4,  1'b0, 16'h2768, 4'b1011, 1'b0, 1'b0};
        tv[16] = '{0, 4'b1101, 7'h24, 4,  1'b0, 16'h2768, 4'b1011, 1'b0, 1'b0};
        tv[17] = '{0, 4'b1011, 7'h30, 4,  1'b0, 16'h2768, 4'b1111, 1'b0, 1'b0};
        tv[18] = '{0, 4'b0111, 7'h19, 4,  1'b1, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tv[19] = '{0, 4'b1110, 7'h12, 4,  1'b1, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tv[20] = '{0, 4'b1101, 7'h02, 4,  1'b1, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tv[21] = '{0, 4'b1011, 7'h78, 4,  1'b1, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tv[22] = '{0, 4'b0111, 7'h00, 4,  1'b1, 16'h4321, 4'b1111, 1'b0, 1'b1};
        tv[23] = '{1, 4'b1111, 7'h7F, 0,  1'b1, 16'h8765, 4'b1111, 1'b0, 1'b1};
        tv[24] = '{1, 4'b1111, 7'h7F, 0,  1'b0, 16'h8765, 4'b1111, 1'b0, 1'b1};
        tv[25] = '{2, 4'b1111, 7'h7F, 0,  1'b0, 16'h8765, 4'b1111, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check_all("reset", 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            if (tv[i].kind == 0)
                show(tv[i].an, tv[i].seg, tv[i].hold);
            else
                pulse(tv[i].kind);
            check_all($sformatf("vec%0d", i), tv[i].ov, tv[i].dig, tv[i].dv, tv[i].ep, tv[i].eo);
        end

        // Reset in the middle of a frame discards the two captured positions.
        show(4'b1110, 7'h40, 4);
        show(4'b1101, 7'h79, 4);
        check_all("pre_rst", 1'b0, 16'h8765, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        an_in  = 4'b1011;
        seg_in = 7'h30;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        show(4'b1011, 7'h30, 4);
        show(4'b0111, 7'h19, 4);
        check_all("post_rst_half", 1'b0, 16'h0000, 4'b1100, 1'b0, 1'b0);
        show(4'b1110, 7'h79, 4);
        show(4'b1101, 7'h24, 4);
        show(4'b1011, 7'h30, 4);
        show(4'b0111, 7'h19, 4);
        check_all("post_rst_full", 1'b1, 16'h4321, 4'b1111, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
